payload_receiver: RTL and testbench
===================================

Name: payload_receiver

Overview:
- Receiving end of the byte-serial Put/Free payload link.
- Accepts beats of 8 bits from a serial producer and reassembles them into one 32-bit `pay` word (fields a,b,c,d).
- Presents the word to a downstream consumer over a parallel Put/Free handshake.
- Single-word buffer; flow-controls the link by dropping Free while a word is held; aborts stalled partial words on timeout.

Parameters:
- TIMEOUT, 16, idle cycles allowed mid-word between beats before the partial word is aborted; 0 disables the timeout.
- CNT_W, 16, width of the delivered-word statistics counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- s_put  input  1  link: sender has a valid beat on s_in.
- s_in  input  8  link: beat data, MSB-first (a first, d last).
- s_free  output  1  link: receiver can accept a beat this cycle.
- m_put  output  1  downstream: m_payload valid.
- m_payload  output  32  downstream: assembled word, type `pay`.
- m_free  input  1  downstream: consumer accepts this cycle.
- err_timeout  output  1  one-cycle pulse when a partial word is aborted.
- err_parity  output  1  one-cycle pulse on parity mismatch (macro only).
- word_cnt  output  CNT_W  count of words delivered downstream.

Behaviour:
- Beat transfer occurs on a posedge where s_put && s_free. Word transfer occurs on a posedge where m_put && m_free.
- Reset values: s_free=0 while reset is asserted and 1 in the first cycle after release; m_put=0; m_payload=0; err_*=0; word_cnt=0; beat index=0; timer=0; state RECV.
- State RECV:
  - s_free=1, m_put=0.
  - Each beat is shifted into the assembly register at position a,b,c,d by beat index 0..3.
  - Index increments per beat.
  - On the final beat (index 3, or the parity beat with the macro), go to HOLD next cycle.
- State HOLD:
  - s_free=0; m_put=1; m_payload stable and equal to the assembled word.
  - On a word transfer: word_cnt+1 (wraps at 2^CNT_W), index cleared, return to RECV.
  - s_free is 1 on the following cycle; no same-cycle bypass.
- Latency: m_put asserts 1 cycle after the last beat edge. Minimum word period is 4 beats + 1 HOLD cycle = 5 cycles.
- Timeout:
  - Applies only in RECV with index>0.
  - The timer counts cycles with no beat transfer and resets to 0 on each beat.
  - When it reaches TIMEOUT: discard the partial word, clear index, pulse err_timeout for 1 cycle, stay in RECV.
  - If a beat arrives on the same edge the timer expires, the beat wins and no abort occurs.
- HOLD never times out; the downstream may stall indefinitely.
- A beat presented during HOLD is not taken: s_free=0, and the sender must hold s_put and s_in.
- Asynchronous reset mid-word or in HOLD discards everything immediately and returns all outputs to reset values.
- m_payload changes only on entry to HOLD and keeps its value in RECV.

Optional Feature:
- Macro PAYLOAD_PARITY_EN.
- Defined:
  - Each word carries a 5th beat equal to a^b^c^d.
  - On the 5th beat, if it matches, enter HOLD.
  - If it mismatches, discard the word, pulse err_parity, return to RECV with index 0, and leave word_cnt unchanged.
  - Minimum word period is 6 cycles.
- Undefined: 4 beats per word; err_parity tied 0.

Decomposition:
- Shared package `handshake_pkg`: typedef `pay` (packed a,b,c,d bytes), localparam BEAT_W=8, localparam BEATS_PER_WORD=4, enum `rx_state_t` {RECV, HOLD}.
- One sub-module: `beat_timer` (TIMEOUT-bounded counter with clear, enable and expire outputs).

Test Plan:
- Reset, then beats 11,22,33,44 back-to-back with m_free=1 -> m_put=1 for 1 cycle with m_payload=32'h11223344 (a=8'h11); word_cnt=1; s_free=0 only in the HOLD cycle.
- Beats AA,BB,CC,DD with m_free=0 for 10 cycles -> m_put held high, payload stable at 32'hAABBCCDD, s_free=0 throughout; then the next word 01,02,03,04 is accepted only after m_free rises.
- TIMEOUT=16: beats 55,66, then s_put=0 for 16 cycles -> err_timeout pulses exactly once, no m_put; the next 4 beats 01,02,03,04 yield 32'h01020304.
- Beats 11,22,33, then reset asserted on the cycle before beat 44 -> m_put stays 0, word_cnt stays 0; a full 4-beat word after release is delivered correctly.
- PAYLOAD_PARITY_EN: beats 11,22,33,44 with parity 44 -> delivered. Same beats with parity 00 -> err_parity pulse, no m_put, word_cnt unchanged.
- word_cnt wrap with CNT_W=2: deliver 5 words -> word_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared types for the byte-serial Put/Free payload link.
// Contents:
//   BEAT_W          - width of one serial beat.
//   BEATS_PER_WORD  - data beats per word (parity beat excluded).
//   pay             - assembled word: a is the first beat and the MSB byte, d is the last.
//   rx_state_t      - receiver state: RECV (assembling) or HOLD (word offered downstream).
//   pay_parity()    - XOR of the four data bytes, carried as the optional parity beat.
package handshake_pkg;

  localparam int BEAT_W         = 8;
  localparam int BEATS_PER_WORD = 4;

  typedef struct packed {
    logic [BEAT_W-1:0] a;
    logic [BEAT_W-1:0] b;
    logic [BEAT_W-1:0] c;
    logic [BEAT_W-1:0] d;
  } pay;

  typedef enum logic {
    RECV = 1'b0,
    HOLD = 1'b1
  } rx_state_t;

  // Byte-wise parity beat that accompanies a word on the link
  function automatic logic [BEAT_W-1:0] pay_parity(input pay p);
    return p.a ^ p.b ^ p.c ^ p.d;
  endfunction

endpackage

// File: rtl/payload_receiver_beat_timer.sv
// beat_timer: idle-cycle counter that bounds the gap between beats of a partial word.
// Ports:
//   clk    - clock
//   reset  - asynchronous active-high reset
//   clr    - a beat transferred this cycle; restart the idle count
//   en     - a partial word is pending, so idle cycles are counted
//   expire - this edge is the TIMEOUT-th consecutive idle cycle (never set when clr is high)
// TIMEOUT = 0 removes the counter and expire stays low.
module beat_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

      logic [TW-1:0] cnt_r;
      logic          expire_s;

      // Expiry happens on the TIMEOUT-th idle edge; a beat on that edge wins
      always_comb begin
        if (en && !clr && (cnt_r == TW'(TIMEOUT - 1))) begin
          expire_s = 1'b1;
        end else begin
          expire_s = 1'b0;
        end
      end

      // Idle-cycle counter, restarted by beats, by expiry and whenever nothing is pending
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_r <= '0;
        end else if (clr || !en || expire_s) begin
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + TW'(1);
        end
      end

      assign expire = expire_s;
    end
  endgenerate

endmodule

// File: rtl/payload_receiver.sv
// payload_receiver: receiving end of the byte-serial Put/Free payload link.
// Reassembles 8-bit beats (a first, d last) into one 32-bit word, holds it in a
// single-word buffer and offers it downstream over a parallel Put/Free handshake.
// While a word is held, s_free stays low. A stalled partial word is aborted after TIMEOUT
// idle cycles.
// Optional build macro PAYLOAD_PARITY_EN: adds a fifth beat (a^b^c^d) to each word.
// A word with a bad parity beat is discarded and err_parity pulses.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   s_put, s_in - link: beat valid and beat data
//   s_free      - link: receiver accepts a beat this cycle
//   m_put       - downstream: m_payload valid
//   m_payload   - downstream: assembled word
//   m_free      - downstream: consumer accepts this cycle
//   err_timeout - one-cycle pulse when a partial word is aborted
//   err_parity  - one-cycle pulse on parity mismatch (tied low without the macro)
//   word_cnt    - words delivered downstream, wrapping at 2^CNT_W
module payload_receiver
  import handshake_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_put,
  input  logic [7:0]       s_in,
  output logic             s_free,
  output logic             m_put,
  output logic [31:0]      m_payload,
  input  logic             m_free,
  output logic             err_timeout,
  output logic             err_parity,
  output logic [CNT_W-1:0] word_cnt
);

`ifdef PAYLOAD_PARITY_EN
  localparam logic [2:0] LAST_IDX = 3'(BEATS_PER_WORD);
`else
  localparam logic [2:0] LAST_IDX = 3'(BEATS_PER_WORD - 1);
`endif

  rx_state_t        state_r;
  logic             rdy_r;
  logic             m_put_r;
  pay               pay_r;
  pay               asm_r;
  pay               nxt_word_s;
  logic [2:0]       idx_r;
  logic             err_timeout_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic             beat_s;
  logic             timer_en_s;
  logic             expire_s;

  // rdy_r resets to 1, so gating with reset gives s_free=0 during reset and 1 immediately after release
  assign s_free = rdy_r & ~reset;
  assign beat_s = s_put & s_free;

  // Assembly register with the current beat merged in at its byte position
  always_comb begin
    nxt_word_s = asm_r;
    case (idx_r)
      3'd0:    nxt_word_s.a = s_in;
      3'd1:    nxt_word_s.b = s_in;
      3'd2:    nxt_word_s.c = s_in;
      3'd3:    nxt_word_s.d = s_in;
      default: nxt_word_s = asm_r;
    endcase
  end

  // Only a partial word in RECV can time out; HOLD may stall forever
  always_comb begin
    if ((state_r == RECV) && (idx_r != 3'd0)) begin
      timer_en_s = 1'b1;
    end else begin
      timer_en_s = 1'b0;
    end
  end

  beat_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_beat_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (beat_s),
    .en     (timer_en_s),
    .expire (expire_s)
  );

`ifdef PAYLOAD_PARITY_EN
  logic err_parity_r;
  assign err_parity = err_parity_r;
`else
  assign err_parity = 1'b0;
`endif

  // Receive/hold state machine with all handshake and status outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= RECV;
      rdy_r         <= 1'b1;
      m_put_r       <= 1'b0;
      pay_r         <= '0;
      asm_r         <= '0;
      idx_r         <= 3'd0;
      err_timeout_r <= 1'b0;
      word_cnt_r    <= '0;
`ifdef PAYLOAD_PARITY_EN
      err_parity_r  <= 1'b0;
`endif
    end else begin
      err_timeout_r <= 1'b0;
`ifdef PAYLOAD_PARITY_EN
      err_parity_r  <= 1'b0;
`endif
      case (state_r)
        RECV: begin
          if (beat_s) begin
            if (idx_r == LAST_IDX) begin
`ifdef PAYLOAD_PARITY_EN
              if (s_in == pay_parity(asm_r)) begin
                pay_r   <= asm_r;
                state_r <= HOLD;
                m_put_r <= 1'b1;
                rdy_r   <= 1'b0;
              end else begin
                err_parity_r <= 1'b1;
                idx_r        <= 3'd0;
                asm_r        <= '0;
              end
`else
              asm_r   <= nxt_word_s;
              pay_r   <= nxt_word_s;
              state_r <= HOLD;
              m_put_r <= 1'b1;
              rdy_r   <= 1'b0;
`endif
            end else begin
              asm_r <= nxt_word_s;
              idx_r <= idx_r + 3'd1;
            end
          end else if (expire_s) begin
            asm_r         <= '0;
            idx_r         <= 3'd0;
            err_timeout_r <= 1'b1;
          end else begin
            asm_r <= asm_r;
          end
        end
        HOLD: begin
          if (m_free) begin
            state_r    <= RECV;
            m_put_r    <= 1'b0;
            rdy_r      <= 1'b1;
            idx_r      <= 3'd0;
            word_cnt_r <= word_cnt_r + CNT_W'(1);
          end else begin
            m_put_r <= 1'b1;
          end
        end
        default: begin
          state_r <= RECV;
          m_put_r <= 1'b0;
          rdy_r   <= 1'b1;
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

  assign m_put       = m_put_r;
  assign m_payload   = pay_r;
  assign err_timeout = err_timeout_r;
  assign word_cnt    = word_cnt_r;

endmodule

// File: tb/tb_payload_receiver.sv
// Scoreboard bench for payload_receiver. The driver pushes each complete, valid word
// into the expected queue. A negedge monitor pops entries as downstream transfers
// happen. It also checks the word count, the s_free/m_put relationship and the reset
// values.
module tb_payload_receiver;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             s_put = 1'b0;
  logic [7:0]       s_in = 8'h00;
  logic             s_free;
  logic             m_put;
  logic [31:0]      m_payload;
  logic             m_free;
  logic             err_timeout;
  logic             err_parity;
  logic [CNT_W-1:0] word_cnt;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int exp_cnt = 0;
  bit pend_cnt = 1'b0;
  int put_cycles = 0;
  int to_pulses = 0;
  int par_pulses = 0;
  bit free_rand = 1'b0;
  bit free_force = 1'b1;

  payload_receiver #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .s_put(s_put), .s_in(s_in), .s_free(s_free),
    .m_put(m_put), .m_payload(m_payload), .m_free(m_free),
    .err_timeout(err_timeout), .err_parity(err_parity), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // downstream consumer: forced level or random acceptance
  initial begin
    m_free = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_free = free_rand ? ($urandom_range(0, 3) != 0) : free_force;
    end
  end

  // monitor / scoreboard: values seen at negedge are the ones the next posedge acts on
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("reset_vals", {m_put, s_free, err_timeout, err_parity, 2'(word_cnt), m_payload[25:0]}, 32'h0);
        exp_q.delete();
        exp_cnt = 0;
        pend_cnt = 1'b0;
      end else begin
        if (pend_cnt) begin
          chk("word_cnt", 32'(word_cnt), 32'(exp_cnt % (1 << CNT_W)));
          pend_cnt = 1'b0;
        end
        chk("s_free_vs_m_put", 32'(s_free), 32'(!m_put));
        if (err_timeout) to_pulses++;
        if (err_parity) par_pulses++;
        if (m_put) begin
          put_cycles++;
          if (exp_q.size() == 0) begin
            chk("spurious_put", 32'(m_put), 32'h0);
          end else begin
            chk("payload", m_payload, exp_q[0]);
            if (m_free) begin
              void'(exp_q.pop_front());
              exp_cnt++;
              pend_cnt = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic send_beat(input logic [7:0] b);
    int n;
    bit ok;
    s_put = 1'b1;
    s_in  = b;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (s_free) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      failures++;
      $display("FAIL beat_accept_timeout actual=stalled required=accepted beat=%h", b);
    end
    @(posedge clk); #1;
    s_put = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit bad, input int max_gap);
    logic [7:0] par;
    par = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`ifndef PAYLOAD_PARITY_EN
    if (!bad) exp_q.push_back(w);
`endif
    for (int i = 3; i >= 0; i--) begin
      send_beat(w[i*8 +: 8]);
      if (max_gap > 0 && i > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
`ifdef PAYLOAD_PARITY_EN
    if (!bad) exp_q.push_back(w);
    send_beat(bad ? (par ^ 8'hFF) : par);
`else
    par = par;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    s_put = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("s_free_after_release", 32'(s_free), 32'h1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int pc0, tp0, pp0;
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc0, tp0;
    do_reset();
    chk("reset_m_put", 32'(m_put), 32'h0);

    // back-to-back word, consumer always ready
    free_force = 1'b1;
    idle(2);
    pc0 = put_cycles;
    send_word(32'h11223344, 1'b0, 0);
    chk("latency_m_put", 32'(m_put), 32'h1);
    chk("latency_payload", m_payload, 32'h11223344);
    idle(4);
    chk("put_one_cycle", 32'(put_cycles - pc0), 32'h1);
    chk("word_cnt_1", 32'(word_cnt), 32'h1);
    chk("payload_kept_in_recv", m_payload, 32'h11223344);

    // consumer stalls with a word held; the next word is accepted only after release
    free_force = 1'b0;
    idle(2);
    send_word(32'hAABBCCDD, 1'b0, 0);
    fork
      send_word(32'h01020304, 1'b0, 0);
      begin
        repeat (10) begin
          chk("stall_m_put", 32'(m_put), 32'h1);
          chk("stall_payload", m_payload, 32'hAABBCCDD);
          idle(1);
        end
        free_force = 1'b1;
      end
    join
    idle(4);
    chk("word_cnt_3", 32'(word_cnt), 32'h3);

    // timeout of a partial word
    tp0 = to_pulses;
    pc0 = put_cycles;
    send_beat(8'h55);
    send_beat(8'h66);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("no_timeout_at_15", 32'(to_pulses - tp0), 32'h0);
    idle(5);
    chk("timeout_once", 32'(to_pulses - tp0), 32'h1);
    chk("no_put_after_abort", 32'(put_cycles - pc0), 32'h0);
    send_word(32'h01020304, 1'b0, 0);
    idle(3);

    // reset in the middle of a word
    send_beat(8'h11);
    send_beat(8'h22);
    send_beat(8'h33);
    do_reset();
    idle(2);
    chk("mid_reset_no_put", 32'(m_put), 32'h0);
    chk("mid_reset_word_cnt", 32'(word_cnt), 32'h0);
    send_word(32'hCAFE0B0E, 1'b0, 0);
    idle(3);
    chk("after_reset_word_cnt", 32'(word_cnt), 32'h1);

`ifdef PAYLOAD_PARITY_EN
    begin
      int pp0;
      pp0 = par_pulses;
      send_word(32'h11223344, 1'b0, 0);
      idle(3);
      chk("parity_good_cnt", 32'(word_cnt), 32'h2);
      pc0 = put_cycles;
      send_word(32'h11223344, 1'b1, 0);
      idle(3);
      chk("parity_bad_pulse", 32'(par_pulses - pp0), 32'h1);
      chk("parity_bad_no_put", 32'(put_cycles - pc0), 32'h0);
      chk("parity_bad_cnt", 32'(word_cnt), 32'h2);
    end
`endif

    // randomized words with random gaps and random downstream acceptance
    free_rand = 1'b1;
    for (int k = 0; k < 30; k++) begin
      send_word($urandom, 1'b0, 3);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
    end
    free_rand = 1'b0;
    free_force = 1'b1;
    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        idle(1);
        n++;
      end
    end
    idle(2);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("timeouts_total", 32'(to_pulses), 32'h1);
`ifndef PAYLOAD_PARITY_EN
    chk("no_parity_pulse", 32'(par_pulses), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
